nes_sram_arbiter: RTL and testbench
===================================

# nes_sram_arbiter

Sequences the single external SRAM that holds PRG RAM, PRG ROM and CHR banks, sharing it between the PPU, CPU and cartridge-image loader address streams produced by the mappers. Each requester presents an already-mapped 20-bit SRAM address. The block grants one requester at a time, drives the SRAM strobes through a fixed setup/access sequence, and returns read data with a valid pulse. PPU has strict priority; CPU and loader alternate round-robin.

## Interface
- ADDR_W, 20, SRAM address width
- DATA_W, 8, SRAM data width
- WAIT_CYCLES, 2, ACCESS cycles per transfer; legal range 1..7
- dual_clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- ppu_req / cpu_req / ldr_req  in  1  request; held until ack
- ppu_we / cpu_we / ldr_we  in  1  1 = write, 0 = read
- ppu_addr / cpu_addr / ldr_addr  in  ADDR_W  mapped SRAM address
- ppu_wdata / cpu_wdata / ldr_wdata  in  DATA_W  write data
- ppu_ack / cpu_ack / ldr_ack  out  1  one-cycle grant pulse; inputs latched this cycle
- ppu_rvalid / cpu_rvalid / ldr_rvalid  out  1  one-cycle read-data pulse
- rdata  out  DATA_W  read data, shared; valid when any rvalid is high
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_in  in  DATA_W  SRAM data bus input
- sram_dq_out  out  DATA_W  SRAM data bus output
- sram_dq_oe  out  1  drive sram_dq_out onto the bus
- sram_ce_n, sram_oe_n, sram_we_n  out  1  active-low SRAM strobes
- ldr_* ports exist only when SRAM_ARB_LOADER_EN is defined.

## Operation
- States: IDLE, SETUP, ACCESS. ACCESS lasts WAIT_CYCLES cycles via a 3-bit counter.
- IDLE: if any req is high, pick a winner and pulse its ack. Latch addr, we, wdata and winner id, then go to SETUP. Otherwise stay in IDLE.
- Priority: ppu > {cpu, ldr}. Between cpu and ldr, a 1-bit rr pointer chooses. The pointer moves to the other requester whenever cpu or ldr is granted; a PPU grant leaves it unchanged.
- SETUP: sram_addr = latched address, sram_ce_n = 0. Write: sram_dq_oe = 1. Read: sram_oe_n = 0.
- ACCESS: same as SETUP, plus sram_we_n = 0 for writes. On the last ACCESS cycle a read samples sram_dq_in into rdata. Return to IDLE.
- Read completion: the winner's rvalid pulses in the IDLE cycle following ACCESS. That IDLE may grant a new request in the same cycle.
- Idle outputs: sram_ce_n, sram_oe_n, sram_we_n = 1 and sram_dq_oe = 0. sram_addr holds its last value. rdata holds until the next read completes.
- A req dropped before its ack causes no access. Writes produce no rvalid.
- WAIT_CYCLES outside 1..7: elaboration-time assertion failure.

## Timing
- Transfer period is 2 + WAIT_CYCLES cycles, ack edge to ack edge (default 4).
- Read latency, ack to rvalid: 2 + WAIT_CYCLES cycles.
- sram_addr and sram_dq_out are stable from SETUP through the last ACCESS cycle. sram_we_n is low only inside ACCESS, giving one cycle of address/data setup and a hold into IDLE.
- Reset value of every output: all acks and rvalids = 0, rdata = 0, sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0, all strobes = 1. State = IDLE, rr pointer = cpu.
- Reset asserted mid-transfer: strobes deassert and sram_dq_oe drops asynchronously. No rvalid or ack is issued for the aborted transfer.

## Configuration
- SRAM_ARB_LOADER_EN defined: loader port present and arbitrated round-robin with the CPU.
- Not defined: ldr_* ports and the rr pointer are removed. The CPU is always granted when the PPU is not requesting.

## Structure
- Package nes_sram_arb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS)
  - requester id enum (REQ_PPU, REQ_CPU, REQ_LDR)
  - WAIT_CYCLES legal-range constants
- Sub-module nes_sram_arb_picker: combinational priority/round-robin selector taking the req vector and rr pointer, returning the one-hot grant.

## Test plan
- cpu read of 0x04000 with SRAM model returning 0xA9, WAIT_CYCLES = 2 -> cpu_ack at cycle 0, sram_oe_n low in cycles 1–3, cpu_rvalid at cycle 4 with rdata = 0xA9.
- ppu write 0x55 to 0x24010 -> sram_we_n low for exactly WAIT_CYCLES cycles, sram_dq_oe high from SETUP to the last ACCESS cycle, no rvalid, model stores 0x55.
- ppu, cpu and ldr all requesting continuously -> grant order ppu, ppu, … With ppu dropped: cpu, ldr, cpu, ldr, each 4 cycles apart.
- Read completion coinciding with a pending cpu req -> rvalid and the new cpu_ack in the same cycle, no idle gap.
- reset pulsed during ACCESS of a read -> strobes high and sram_dq_oe low immediately, no rvalid, next grant after reset is cpu over ldr.
- Without SRAM_ARB_LOADER_EN -> cpu read of 0x00123 returns the model's byte, latency unchanged.

Source files
------------

// File: rtl/nes_sram_arb_pkg.sv
// Shared types and constants for the NES external SRAM arbiter.
// State encoding, requester ids and the legal ACCESS-length range.
package nes_sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   typedef enum logic [1:0] {
      REQ_PPU,
      REQ_CPU,
      REQ_LDR
   } req_id_t;

   localparam int WAIT_MIN = 1;
   localparam int WAIT_MAX = 7;

endpackage

// File: rtl/nes_sram_arb_picker.sv
// Combinational winner selection: PPU first, then CPU/loader by rr.
// Ports: req[2:0] (ppu,cpu,ldr by id), rr (1 = loader preferred), grant one-hot.
module nes_sram_arb_picker
   import nes_sram_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic       rr,
   output logic [2:0] grant
);

   always_comb begin
      grant = 3'b000;
      if (req[REQ_PPU]) begin
         grant[REQ_PPU] = 1'b1;
      end else if (req[REQ_CPU] && req[REQ_LDR]) begin
         if (rr) grant[REQ_LDR] = 1'b1;
         else    grant[REQ_CPU] = 1'b1;
      end else if (req[REQ_CPU]) begin
         grant[REQ_CPU] = 1'b1;
      end else if (req[REQ_LDR]) begin
         grant[REQ_LDR] = 1'b1;
      end
   end

endmodule

// File: rtl/nes_sram_arbiter.sv
// Shares one async SRAM between PPU, CPU and (SRAM_ARB_LOADER_EN) loader.
// Ports: per-requester req/we/addr/wdata in, ack/rvalid out; shared rdata;
// sram_addr, sram_dq_in/out/oe and active-low ce/oe/we strobes.
module nes_sram_arbiter
   import nes_sram_arb_pkg::*;
#(
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              dual_clock,
   input  logic              reset,
   input  logic              ppu_req,
   input  logic              ppu_we,
   input  logic [ADDR_W-1:0] ppu_addr,
   input  logic [DATA_W-1:0] ppu_wdata,
   output logic              ppu_ack,
   output logic              ppu_rvalid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_rvalid,
`ifdef SRAM_ARB_LOADER_EN
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_ack,
   output logic              ldr_rvalid,
`endif
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [DATA_W-1:0] sram_dq_in,
   output logic [DATA_W-1:0] sram_dq_out,
   output logic              sram_dq_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
      $error("nes_sram_arbiter: WAIT_CYCLES must be 1..7");
   end

   state_t     state, state_nxt;
   logic [2:0] cnt;
   logic       lat_we;
   req_id_t    lat_id;
   logic [2:0] req_vec, grant;
   logic       rr_sel;
   logic       last, rd_done;

`ifdef SRAM_ARB_LOADER_EN
   logic rr;
   assign req_vec = {ldr_req, cpu_req, ppu_req};
   assign rr_sel  = rr;
`else
   logic unused_ldr_grant;
   assign req_vec          = {1'b0, cpu_req, ppu_req};
   assign rr_sel           = 1'b0;
   assign unused_ldr_grant = grant[REQ_LDR];
`endif

   nes_sram_arb_picker u_picker (
      .req   (req_vec),
      .rr    (rr_sel),
      .grant (grant)
   );

   assign last    = (state == ACCESS) && (cnt == 3'(WAIT_CYCLES - 1));
   assign rd_done = last && !lat_we;

   // state register
   always_ff @(posedge dual_clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= (state == ACCESS) ? cnt + 3'd1 : 3'd0;
      end
   end

   // next state
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (|grant) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // request latch, read capture and completion pulses
   always_ff @(posedge dual_clock or posedge reset) begin
      if (reset) begin
         sram_addr   <= '0;
         sram_dq_out <= '0;
         lat_we      <= 1'b0;
         lat_id      <= REQ_PPU;
         rdata       <= '0;
         ppu_rvalid  <= 1'b0;
         cpu_rvalid  <= 1'b0;
`ifdef SRAM_ARB_LOADER_EN
         ldr_rvalid  <= 1'b0;
         rr          <= 1'b0;
`endif
      end else begin
         ppu_rvalid <= rd_done && (lat_id == REQ_PPU);
         cpu_rvalid <= rd_done && (lat_id == REQ_CPU);
`ifdef SRAM_ARB_LOADER_EN
         ldr_rvalid <= rd_done && (lat_id == REQ_LDR);
`endif
         if (rd_done) rdata <= sram_dq_in;
         if (state == IDLE && |grant) begin
            unique case (1'b1)
               grant[REQ_PPU]: begin
                  lat_id      <= REQ_PPU;
                  lat_we      <= ppu_we;
                  sram_addr   <= ppu_addr;
                  sram_dq_out <= ppu_wdata;
               end
               grant[REQ_CPU]: begin
                  lat_id      <= REQ_CPU;
                  lat_we      <= cpu_we;
                  sram_addr   <= cpu_addr;
                  sram_dq_out <= cpu_wdata;
`ifdef SRAM_ARB_LOADER_EN
                  rr          <= 1'b1;
`endif
               end
`ifdef SRAM_ARB_LOADER_EN
               grant[REQ_LDR]: begin
                  lat_id      <= REQ_LDR;
                  lat_we      <= ldr_we;
                  sram_addr   <= ldr_addr;
                  sram_dq_out <= ldr_wdata;
                  rr          <= 1'b0;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   // strobes and grant pulses; reset forces IDLE so strobes drop at once
   always_comb begin
      sram_ce_n  = 1'b1;
      sram_oe_n  = 1'b1;
      sram_we_n  = 1'b1;
      sram_dq_oe = 1'b0;
      ppu_ack    = 1'b0;
      cpu_ack    = 1'b0;
`ifdef SRAM_ARB_LOADER_EN
      ldr_ack    = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            ppu_ack = grant[REQ_PPU] && !reset;
            cpu_ack = grant[REQ_CPU] && !reset;
`ifdef SRAM_ARB_LOADER_EN
            ldr_ack = grant[REQ_LDR] && !reset;
`endif
         end
         SETUP: begin
            sram_ce_n  = 1'b0;
            sram_dq_oe = lat_we;
            sram_oe_n  = lat_we;
         end
         ACCESS: begin
            sram_ce_n  = 1'b0;
            sram_dq_oe = lat_we;
            sram_oe_n  = lat_we;
            sram_we_n  = !lat_we;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_nes_sram_arbiter.sv
// Self-checking bench for nes_sram_arbiter: directed table, hand
// sequences and random traffic checked against a transaction model.
module tb_nes_sram_arbiter;
   import nes_sram_arb_pkg::*;

   localparam int AW  = 20;
   localparam int DW  = 8;
   localparam int W   = 2;
   localparam int PER = 2 + W;
`ifdef SRAM_ARB_LOADER_EN
   localparam int NREQ = 3;
`else
   localparam int NREQ = 2;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [2:0] req, we;
   logic [AW-1:0] addr [3];
   logic [DW-1:0] wdata [3];
   logic ppu_ack, cpu_ack, ldr_ack;
   logic ppu_rvalid, cpu_rvalid, ldr_rvalid;
   logic [DW-1:0] rdata, sram_dq_in, sram_dq_out;
   logic [AW-1:0] sram_addr;
   logic sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
   logic [2:0] ackv, rvv, last_ack;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifndef SRAM_ARB_LOADER_EN
   assign ldr_ack    = 1'b0;
   assign ldr_rvalid = 1'b0;
`endif
   assign ackv = {ldr_ack, cpu_ack, ppu_ack};
   assign rvv  = {ldr_rvalid, cpu_rvalid, ppu_rvalid};

   nes_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
      .dual_clock  (clk),
      .reset       (rst),
      .ppu_req     (req[0]),
      .ppu_we      (we[0]),
      .ppu_addr    (addr[0]),
      .ppu_wdata   (wdata[0]),
      .ppu_ack     (ppu_ack),
      .ppu_rvalid  (ppu_rvalid),
      .cpu_req     (req[1]),
      .cpu_we      (we[1]),
      .cpu_addr    (addr[1]),
      .cpu_wdata   (wdata[1]),
      .cpu_ack     (cpu_ack),
      .cpu_rvalid  (cpu_rvalid),
`ifdef SRAM_ARB_LOADER_EN
      .ldr_req     (req[2]),
      .ldr_we      (we[2]),
      .ldr_addr    (addr[2]),
      .ldr_wdata   (wdata[2]),
      .ldr_ack     (ldr_ack),
      .ldr_rvalid  (ldr_rvalid),
`endif
      .rdata       (rdata),
      .sram_addr   (sram_addr),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_out (sram_dq_out),
      .sram_dq_oe  (sram_dq_oe),
      .sram_ce_n   (sram_ce_n),
      .sram_oe_n   (sram_oe_n),
      .sram_we_n   (sram_we_n)
   );

   function automatic logic [7:0] f(input logic [19:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // SRAM device model
   logic [7:0] mem [0:(1<<20)-1];
   assign sram_dq_in = mem[sram_addr];
   always @(posedge clk)
      if (!sram_ce_n && !sram_we_n) mem[sram_addr] = sram_dq_out;

   // expected memory contents as seen by completed grants
   logic [7:0] shadow [int];
   function automatic logic [7:0] shadow_rd(input logic [19:0] a);
      if (shadow.exists(int'(a))) return shadow[int'(a)];
      return f(a);
   endfunction

   task automatic chk(input bit ok, input string nm,
                      input longint act, input longint exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // transaction-level reference: grant rules, transfer period, read data
   typedef struct { int id; int due; logic [7:0] data; } pend_t;
   pend_t pend[$];
   int busy = 0;
   int rr_m = 1;

   always @(negedge clk) begin : mon
      logic [2:0] exp_ack, exp_rv;
      logic [7:0] exp_d;
      int exp_id;
      exp_ack = 3'b000;
      exp_rv  = 3'b000;
      exp_d   = 8'h00;
      exp_id  = -1;
      if (rst) begin
         pend.delete();
         busy = 0;
         rr_m = 1;
      end else begin
         if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_rv[pend[0].id] = 1'b1;
            exp_d = pend[0].data;
            pend.delete(0);
         end
         if (busy == 0) begin
            if (req[0])                exp_id = 0;
            else if (req[1] && req[2]) exp_id = rr_m;
            else if (req[1])           exp_id = 1;
            else if (req[2])           exp_id = 2;
         end
         if (exp_id >= 0) begin
            exp_ack[exp_id] = 1'b1;
            busy = PER;
            if (exp_id != 0) rr_m = (exp_id == 1) ? 2 : 1;
            if (we[exp_id]) shadow[int'(addr[exp_id])] = wdata[exp_id];
            else pend.push_back('{exp_id, cyc + PER, shadow_rd(addr[exp_id])});
         end
         if (busy > 0) busy--;
      end
      chk(ackv == exp_ack, "mon ack", ackv, exp_ack);
      chk(rvv == exp_rv, "mon rvalid", rvv, exp_rv);
      if (exp_rv != 3'b000) chk(rdata == exp_d, "mon rdata", rdata, exp_d);
      last_ack = ackv;
   end

   task automatic wait_grant(output int id, output int t);
      id = -1;
      t  = -1;
      for (int c = 0; c < 4 * PER && id < 0; c++) begin
         @(negedge clk);
         if (ackv != 3'b000) begin
            id = ackv[0] ? 0 : (ackv[1] ? 1 : 2);
            t  = cyc;
         end
      end
      chk(id >= 0, "grant timeout", id, 0);
   endtask

   task automatic txn(input int id, input logic w, input logic [19:0] a,
                      input logic [7:0] d, input logic [7:0] exp, input string nm);
      int waitc, lat, n_oe, n_we, n_dq;
      bit got;
      @(posedge clk); #1;
      req[id] = 1'b1; we[id] = w; addr[id] = a; wdata[id] = d;
      waitc = 0;
      @(negedge clk);
      while (!ackv[id] && waitc < 20) begin
         waitc++;
         @(negedge clk);
      end
      chk(waitc == 0, {nm, " ack cycle"}, waitc, 0);
      @(posedge clk); #1;
      req[id] = 1'b0;
      lat = 0; got = 0; n_oe = 0; n_we = 0; n_dq = 0;
      for (int c = 1; c <= PER + 2; c++) begin
         @(negedge clk);
         if (!sram_oe_n) n_oe++;
         if (!sram_we_n) n_we++;
         if (sram_dq_oe) n_dq++;
         if (rvv[id] && !got) begin
            got = 1;
            lat = c;
            if (!w) chk(rdata == exp, {nm, " rdata"}, rdata, exp);
         end
      end
      if (w) begin
         chk(!got, {nm, " no rvalid"}, got, 0);
         chk(n_we == W, {nm, " we_n low"}, n_we, W);
         chk(n_dq == W + 1, {nm, " dq_oe high"}, n_dq, W + 1);
         chk(n_oe == 0, {nm, " oe_n low"}, n_oe, 0);
         chk(mem[a] == d, {nm, " stored"}, mem[a], d);
      end else begin
         chk(got && lat == PER, {nm, " latency"}, lat, PER);
         chk(n_oe == W + 1, {nm, " oe_n low"}, n_oe, W + 1);
         chk(n_we == 0, {nm, " we_n low"}, n_we, 0);
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic drain();
      @(posedge clk); #1;
      req = 3'b000;
      repeat (PER + 2) @(negedge clk);
   endtask

   typedef struct {
      int         id;
      logic       w;
      logic [19:0] a;
      logic [7:0] d;
      logic [7:0] exp;
   } vec_t;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      vec_t tv[$];
      int g, t, tp, expg;

      tv.push_back('{1, 1'b0, 20'h04000, 8'h00, 8'hA9});
      tv.push_back('{0, 1'b1, 20'h24010, 8'h55, 8'h55});
      tv.push_back('{0, 1'b0, 20'h24010, 8'h00, 8'h55});
      tv.push_back('{1, 1'b0, 20'h00123, 8'h00, 8'h1E});
      tv.push_back('{1, 1'b1, 20'hFFFFF, 8'h00, 8'h00});
      tv.push_back('{0, 1'b0, 20'hFFFFF, 8'h00, 8'h00});
      tv.push_back('{0, 1'b0, 20'h00000, 8'h00, 8'h3C});
`ifdef SRAM_ARB_LOADER_EN
      tv.push_back('{2, 1'b1, 20'h10020, 8'hC3, 8'hC3});
      tv.push_back('{1, 1'b0, 20'h10020, 8'h00, 8'hC3});
      tv.push_back('{2, 1'b0, 20'h00123, 8'h00, 8'h1E});
`endif

      for (int i = 0; i < (1 << 20); i++) mem[i] = f(20'(i));
      mem[20'h04000] = 8'hA9;
      shadow[32'h04000] = 8'hA9;

      rst = 1'b1;
      req = 3'b010;
      we  = 3'b000;
      for (int i = 0; i < 3; i++) begin
         addr[i]  = '0;
         wdata[i] = '0;
      end
      repeat (2) @(negedge clk);
      chk(ackv == 3'b000, "reset ack", ackv, 0);
      chk(rvv == 3'b000, "reset rvalid", rvv, 0);
      chk(rdata == 8'h00, "reset rdata", rdata, 0);
      chk(sram_addr == 20'h0, "reset addr", sram_addr, 0);
      chk(sram_dq_out == 8'h00, "reset dq_out", sram_dq_out, 0);
      chk(sram_dq_oe == 1'b0, "reset dq_oe", sram_dq_oe, 0);
      chk({sram_ce_n, sram_oe_n, sram_we_n} == 3'b111, "reset strobes",
          {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
      req = 3'b000;
      @(posedge clk); #1 rst = 1'b0;

      foreach (tv[i])
         txn(tv[i].id, tv[i].w, tv[i].a, tv[i].d, tv[i].exp, $sformatf("vec%0d", i));

      // read completion coinciding with a held cpu request
      @(posedge clk); #1;
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 20'h00200;
      wait_grant(g, t);
      chk(g == 1, "b2b first grant", g, 1);
      @(posedge clk); #1 addr[1] = 20'h00201;
      repeat (PER - 1) @(negedge clk);
      @(negedge clk);
      chk(cpu_rvalid && cpu_ack, "b2b rvalid+ack", {cpu_rvalid, cpu_ack}, 2'b11);
      drain();

      // priority and round-robin order
      pulse_reset();
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
         req[i] = 1'b1; we[i] = 1'b0; addr[i] = 20'(32'h00400 + i);
      end
      tp = -1;
      for (int k = 0; k < 3; k++) begin
         wait_grant(g, t);
         chk(g == 0, "prio ppu", g, 0);
         if (tp >= 0) chk(t - tp == PER, "ppu period", t - tp, PER);
         tp = t;
      end
      @(posedge clk); #1 req[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_grant(g, t);
         expg = (NREQ == 3 && (k % 2) == 1) ? 2 : 1;
         chk(g == expg, "rr order", g, expg);
         chk(t - tp == PER, "rr period", t - tp, PER);
         tp = t;
      end
      drain();

      // reset during ACCESS of a read
      @(posedge clk); #1;
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 20'h00300;
      wait_grant(g, t);
      chk(g == 1, "abort grant", g, 1);
      @(posedge clk); #1 req[1] = 1'b0;
      repeat (2) @(negedge clk);
      chk(!sram_ce_n && !sram_oe_n, "abort access live",
          {sram_ce_n, sram_oe_n}, 2'b00);
      #2 rst = 1'b1;
      #1;
      chk({sram_ce_n, sram_oe_n, sram_we_n} == 3'b111, "abort strobes",
          {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
      chk(sram_dq_oe == 1'b0, "abort dq_oe", sram_dq_oe, 0);
      @(posedge clk); #1;
      req[1] = 1'b1;
      if (NREQ == 3) req[2] = 1'b1;
      we = 3'b000;
      addr[2] = 20'h00310;
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk(cpu_ack && !ldr_ack, "post-reset grant", {ldr_ack, cpu_ack}, 2'b01);
      @(posedge clk); #1 req[1] = 1'b0;
      if (NREQ == 3) begin
         wait_grant(g, t);
         chk(g == 2, "post-reset ldr", g, 2);
      end
      drain();

      // random traffic, checked by the monitor model
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < NREQ; i++) begin
            if (req[i] && last_ack[i]) begin
               req[i] = 1'($urandom_range(0, 1));
            end else if (!req[i]) begin
               req[i] = ($urandom_range(0, 3) == 0);
            end
            if (req[i] && (last_ack[i] || !req[i] || c == 0 || $urandom_range(0, 0) == 0)
                && last_ack[i]) begin
               we[i]    = 1'($urandom_range(0, 1));
               addr[i]  = 20'h01000 | 20'($urandom_range(0, 7));
               wdata[i] = 8'($urandom);
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !last_ack[i] && $urandom_range(0, 7) == 0) begin
               we[i]    = 1'($urandom_range(0, 1));
               addr[i]  = 20'h01000 | 20'($urandom_range(0, 7));
               wdata[i] = 8'($urandom);
            end
         end
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
